discharge_sched_ctrl: RTL and testbench
=======================================

// Module: discharge_sched_ctrl
// PURPOSE
//  Run/stop arbiter and parameter-commit scheduler in front of discharge_control.
//  Merges start/stop requests from SPI and keys and latches faults. Holds Ton/Toff/Ip/waveform
//  updates in shadow registers. Commits them to active registers only at a pulse boundary
//  (pulse_idle), so a discharge pulse never sees mixed parameters. Sits in the clk_100M domain.
// PARAMETERS
//  TON_DEFAULT      16'd100   active Ton after reset (10ns ticks)
//  TOFF_DEFAULT     16'd1000  active Toff after reset
//  IP_DEFAULT       16'd10    active Ip after reset (A)
//  WAVE_DEFAULT     16'h2001  active waveform code after reset
//  TON_MIN          16'd10    Ton below this is rejected
//  IP_MAX           16'd120   Ip above this is rejected
//  COMMIT_TIMEOUT   24'd1000000  cycles a pending update may wait while RUNNING
// PORTS
//  clk              in   1   system clock (clk_100M)
//  rst_n            in   1   asynchronous active-low reset
//  start_req_spi    in   1   1-cycle start pulse, synchronous to clk
//  stop_req_spi     in   1   1-cycle stop pulse
//  start_req_key    in   1   1-cycle start pulse (debounced key)
//  stop_req_key     in   1   1-cycle stop pulse
//  upd_req          in   4   1-cycle update strobes {wave,Ip,Toff,Ton}
//  upd_data         in   64  {wave,Ip,Toff,Ton} 16b each, valid with the matching strobe
//  pulse_idle       in   1   high while discharge_control is in Toff/idle (safe boundary)
//  fault            in   1   level, overcurrent or hardware fault
//  fault_clear      in   1   1-cycle pulse, clears the latched fault
//  machine_en       out  1   run enable to discharge_control
//  Ton_q,Toff_q,Ip_q,wave_q  out 16 each  active parameters
//  param_commit     out  1   1-cycle pulse, the cycle after the active registers change
//  pending          out  4   shadow value awaiting commit {wave,Ip,Toff,Ton}
//  upd_reject       out  1   1-cycle pulse, update refused by the range check
//  commit_timeout   out  1   1-cycle pulse when a pending update reaches COMMIT_TIMEOUT
//  fault_latched    out  1   high in the FAULT state
// BEHAVIOUR
//  Reset values:
//   - state=STOPPED, machine_en=0, fault_latched=0.
//   - pending=0 and all pulse outputs=0.
//   - active registers and shadows hold the *_DEFAULT values.
//   - Timeout counter=0.
//  FSM: STOPPED, RUNNING, DRAIN, FAULT. Registered state; machine_en=(state==RUNNING).
//  Priority in any cycle: fault > stop (spi|key) > start (spi|key).
//  STOPPED:
//   - Go to FAULT if fault=1.
//   - Otherwise go to RUNNING on a start request when no stop request is present the same cycle.
//  RUNNING:
//   - Go to FAULT if fault=1.
//   - Otherwise go to DRAIN on any stop request.
//   - Start requests are ignored.
//  DRAIN: machine_en=0.
//   - Go to FAULT if fault=1.
//   - Otherwise go to STOPPED on the first cycle pulse_idle=1.
//   - Start requests are ignored.
//  FAULT: machine_en=0 and fault_latched=1.
//   - Leave only on fault_clear=1 while fault=0, and go to STOPPED. Start is never implied.
//  Update capture:
//   - upd_req[i]=1 writes slice i into shadow i and sets pending[i] next cycle.
//   - Multiple strobes in the same cycle are allowed.
//   - Reject when Ton<TON_MIN or Ip>IP_MAX or Ip==0. The shadow and pending bit are unchanged
//     and upd_reject pulses on the next cycle.
//  Commit condition:
//   - Condition C = (pending!=0) && (pulse_idle || state!=RUNNING).
//   - On C, every pending shadow is copied to the active registers at the next edge and pending
//     clears. param_commit pulses one cycle after that edge.
//   - Latency is 1 cycle from C to the active value and 2 cycles to the param_commit pulse.
//  Simultaneous strobe and commit:
//   - If upd_req[i] arrives in the cycle C holds, the old shadow i commits.
//   - The new value is captured and pending[i] stays 1 for the next boundary.
//  Timeout:
//   - The counter increments while state==RUNNING and pending!=0. It clears on commit or when
//     pending==0.
//   - On reaching COMMIT_TIMEOUT, commit_timeout pulses once and the counter saturates.
//     Pending is kept.
//   - The counter clears when leaving RUNNING.
//  Reset mid-operation: asynchronous return to all reset values. Pending updates are lost.
// TESTING
//  1. Reset, then start_req_key -> machine_en=1 one cycle later; Ton_q=100, wave_q=0x2001.
//  2. RUNNING with pulse_idle=0, Ton=200 strobe -> pending=0001 and Ton_q stays 100.
//     Raise pulse_idle -> Ton_q=200 one cycle later, param_commit on the following cycle,
//     pending=0.
//  3. Ip=150 strobe -> upd_reject pulse, pending=0, Ip_q unchanged.
//     Ton=5 strobe -> reject.
//  4. start_req_spi and stop_req_key in the same cycle from STOPPED -> stays STOPPED.
//     stop while RUNNING with pulse_idle=0 -> DRAIN, machine_en=0; STOPPED on pulse_idle.
//  5. fault=1 in RUNNING -> FAULT, fault_latched=1.
//     fault_clear while fault=1 -> ignored.
//     fault=0 then fault_clear -> STOPPED, machine_en stays 0.
//  6. COMMIT_TIMEOUT=50, pulse_idle held 0 with a pending Toff update -> commit_timeout pulses
//     once at cycle 50.
//     Then stop; DRAIN ends on pulse_idle -> commit occurs.

Source files
------------

// File: rtl/discharge_sched_ctrl.sv
// Run/stop arbiter plus shadow-register parameter scheduler for discharge_control.
// Parameter updates are held in shadows and only committed at a pulse boundary.
module discharge_sched_ctrl #(
  parameter logic [15:0] TON_DEFAULT    = 16'd100,
  parameter logic [15:0] TOFF_DEFAULT   = 16'd1000,
  parameter logic [15:0] IP_DEFAULT     = 16'd10,
  parameter logic [15:0] WAVE_DEFAULT   = 16'h2001,
  parameter logic [15:0] TON_MIN        = 16'd10,
  parameter logic [15:0] IP_MAX         = 16'd120,
  parameter logic [23:0] COMMIT_TIMEOUT = 24'd1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_req_spi,
  input  logic        stop_req_spi,
  input  logic        start_req_key,
  input  logic        stop_req_key,
  input  logic [3:0]  upd_req,
  input  logic [63:0] upd_data,
  input  logic        pulse_idle,
  input  logic        fault,
  input  logic        fault_clear,
  output logic        machine_en,
  output logic [15:0] Ton_q,
  output logic [15:0] Toff_q,
  output logic [15:0] Ip_q,
  output logic [15:0] wave_q,
  output logic        param_commit,
  output logic [3:0]  pending,
  output logic        upd_reject,
  output logic        commit_timeout,
  output logic        fault_latched
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam logic [63:0] DEFAULTS = {WAVE_DEFAULT, IP_DEFAULT, TOFF_DEFAULT, TON_DEFAULT};

  state_t      state_reg, state_next;
  logic [63:0] shadow_reg, shadow_next;
  logic [63:0] active_reg, active_next;
  logic [3:0]  pending_reg, pending_next;
  logic [23:0] tmo_cnt_reg, tmo_cnt_next;
  logic        tmo_pulse_reg, tmo_pulse_next;
  logic        commit_d_reg;
  logic        param_commit_reg;
  logic        reject_reg;

  logic        start_any;
  logic        stop_any;
  logic        commit;
  logic        ton_ok;
  logic        ip_ok;
  logic [3:0]  valid;
  logic [3:0]  accept;

  assign start_any = start_req_spi | start_req_key;
  assign stop_any  = stop_req_spi | stop_req_key;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_STOPPED: begin
        if (fault)                      state_next = ST_FAULT;
        else if (start_any && !stop_any) state_next = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (fault)         state_next = ST_FAULT;
        else if (stop_any) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fault)           state_next = ST_FAULT;
        else if (pulse_idle) state_next = ST_STOPPED;
      end
      ST_FAULT: begin
        if (fault_clear && !fault) state_next = ST_STOPPED;
      end
      default: state_next = ST_STOPPED;
    endcase
  end

  // Range check is per field: only the offending slice is refused.
  assign ton_ok = (upd_data[15:0] >= TON_MIN);
  assign ip_ok  = (upd_data[47:32] != 16'd0) && (upd_data[47:32] <= IP_MAX);
  assign valid  = {1'b1, ip_ok, 1'b1, ton_ok};
  assign accept = upd_req & valid;

  assign commit = (pending_reg != 4'd0) && (pulse_idle || (state_reg != ST_RUNNING));

  // A strobe in the commit cycle lands in the shadow after the old value is copied out.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign active_next[gi*16 +: 16] = (commit && pending_reg[gi]) ?
                                        shadow_reg[gi*16 +: 16] : active_reg[gi*16 +: 16];
      assign shadow_next[gi*16 +: 16] = accept[gi] ?
                                        upd_data[gi*16 +: 16] : shadow_reg[gi*16 +: 16];
      assign pending_next[gi]         = accept[gi] | (pending_reg[gi] & ~commit);
    end
  endgenerate

  always_comb begin
    tmo_cnt_next   = tmo_cnt_reg;
    tmo_pulse_next = 1'b0;
    if ((state_reg != ST_RUNNING) || (pending_reg == 4'd0) || commit) begin
      tmo_cnt_next = 24'd0;
    end else if (tmo_cnt_reg != COMMIT_TIMEOUT) begin
      tmo_cnt_next   = tmo_cnt_reg + 24'd1;
      tmo_pulse_next = (tmo_cnt_reg == COMMIT_TIMEOUT - 24'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_STOPPED;
      shadow_reg       <= DEFAULTS;
      active_reg       <= DEFAULTS;
      pending_reg      <= 4'd0;
      tmo_cnt_reg      <= 24'd0;
      tmo_pulse_reg    <= 1'b0;
      commit_d_reg     <= 1'b0;
      param_commit_reg <= 1'b0;
      reject_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      shadow_reg       <= shadow_next;
      active_reg       <= active_next;
      pending_reg      <= pending_next;
      tmo_cnt_reg      <= tmo_cnt_next;
      tmo_pulse_reg    <= tmo_pulse_next;
      commit_d_reg     <= commit;
      param_commit_reg <= commit_d_reg;
      reject_reg       <= |(upd_req & ~valid);
    end
  end

  assign machine_en     = (state_reg == ST_RUNNING);
  assign fault_latched  = (state_reg == ST_FAULT);
  assign Ton_q          = active_reg[15:0];
  assign Toff_q         = active_reg[31:16];
  assign Ip_q           = active_reg[47:32];
  assign wave_q         = active_reg[63:48];
  assign pending        = pending_reg;
  assign param_commit   = param_commit_reg;
  assign upd_reject     = reject_reg;
  assign commit_timeout = tmo_pulse_reg;

endmodule

// File: tb/tb_discharge_sched_ctrl.sv
// Directed bench for discharge_sched_ctrl: run/stop arbitration, fault latch,
// shadow commit timing, range rejects and the commit timeout.
module tb_discharge_sched_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_req_spi, stop_req_spi, start_req_key, stop_req_key;
  logic [3:0]  upd_req;
  logic [63:0] upd_data;
  logic        pulse_idle, fault, fault_clear;
  logic        machine_en;
  logic [15:0] Ton_q, Toff_q, Ip_q, wave_q;
  logic        param_commit;
  logic [3:0]  pending;
  logic        upd_reject, commit_timeout, fault_latched;

  int errors = 0;
  int checks = 0;
  int tmo_pulses;

  discharge_sched_ctrl #(.COMMIT_TIMEOUT(24'd50)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_req_spi(start_req_spi), .stop_req_spi(stop_req_spi),
    .start_req_key(start_req_key), .stop_req_key(stop_req_key),
    .upd_req(upd_req), .upd_data(upd_data),
    .pulse_idle(pulse_idle), .fault(fault), .fault_clear(fault_clear),
    .machine_en(machine_en),
    .Ton_q(Ton_q), .Toff_q(Toff_q), .Ip_q(Ip_q), .wave_q(wave_q),
    .param_commit(param_commit), .pending(pending),
    .upd_reject(upd_reject), .commit_timeout(commit_timeout),
    .fault_latched(fault_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [3:0] req, input logic [63:0] data);
    upd_req  = req;
    upd_data = data;
    step();
    upd_req  = 4'd0;
    upd_data = 64'd0;
  endtask

  task automatic pulse_start_key();
    start_req_key = 1'b1; step(); start_req_key = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start_req_spi = 0; stop_req_spi = 0; start_req_key = 0; stop_req_key = 0;
    upd_req = 4'd0; upd_data = 64'd0;
    pulse_idle = 0; fault = 0; fault_clear = 0;

    // 1. reset values and start from the key
    #12;
    check("rst_machine_en", machine_en, 0);
    check("rst_fault_latched", fault_latched, 0);
    check("rst_pending", pending, 0);
    check("rst_param_commit", param_commit, 0);
    check("rst_upd_reject", upd_reject, 0);
    check("rst_commit_timeout", commit_timeout, 0);
    check("rst_Ton_q", Ton_q, 100);
    check("rst_Toff_q", Toff_q, 1000);
    check("rst_Ip_q", Ip_q, 10);
    check("rst_wave_q", wave_q, 16'h2001);
    @(posedge clk); #1 rst_n = 1'b1;
    step();
    pulse_start_key();
    check("start_key_run", machine_en, 1);
    check("run_Ton_q", Ton_q, 100);
    check("run_wave_q", wave_q, 16'h2001);

    // 2. Ton update held until pulse_idle, then commit timing
    strobe(4'b0001, 64'd200);
    check("ton200_pending", pending, 4'b0001);
    check("ton200_held", Ton_q, 100);
    step();
    check("ton200_still_held", Ton_q, 100);
    pulse_idle = 1;
    step();
    check("ton200_committed", Ton_q, 200);
    check("ton200_pending_clr", pending, 0);
    check("ton200_commit_early", param_commit, 0);
    step();
    check("ton200_commit_pulse", param_commit, 1);
    step();
    check("ton200_commit_end", param_commit, 0);

    // strobe in the same cycle as a commit: old shadow commits, new one stays pending
    pulse_idle = 0;
    strobe(4'b0001, 64'd300);
    check("ton300_pending", pending, 4'b0001);
    pulse_idle = 1;
    strobe(4'b0001, 64'd400);
    check("simul_old_commits", Ton_q, 300);
    check("simul_still_pending", pending, 4'b0001);
    step();
    check("simul_new_commits", Ton_q, 400);
    check("simul_pending_clr", pending, 0);
    step();

    // 3. range rejects and a valid multi-field update
    strobe(4'b0100, 64'd150 << 32);
    check("ip150_reject", upd_reject, 1);
    check("ip150_pending", pending, 0);
    check("ip150_Ip_q", Ip_q, 10);
    step();
    check("reject_one_cycle", upd_reject, 0);
    strobe(4'b0001, 64'd5);
    check("ton5_reject", upd_reject, 1);
    check("ton5_pending", pending, 0);
    step();
    check("ton5_Ton_q", Ton_q, 400);
    strobe(4'b0100, 64'd0);
    check("ip0_reject", upd_reject, 1);
    strobe(4'b1100, {16'h3005, 16'd50, 32'd0});
    check("multi_no_reject", upd_reject, 0);
    check("multi_pending", pending, 4'b1100);
    step();
    check("multi_Ip_q", Ip_q, 50);
    check("multi_wave_q", wave_q, 16'h3005);
    check("multi_pending_clr", pending, 0);

    // 4. stop/drain, start ignored in DRAIN, start+stop together in STOPPED
    pulse_idle = 0;
    stop_req_spi = 1; step(); stop_req_spi = 0;
    check("drain_en_low", machine_en, 0);
    pulse_start_key();
    check("drain_ignores_start", machine_en, 0);
    pulse_idle = 1;
    step();
    check("drain_to_stopped", machine_en, 0);
    start_req_spi = 1; stop_req_key = 1; step();
    start_req_spi = 0; stop_req_key = 0;
    check("start_stop_same_cycle", machine_en, 0);
    start_req_spi = 1; step(); start_req_spi = 0;
    check("start_spi_run", machine_en, 1);

    // 5. fault latch and clear
    fault = 1; step();
    check("fault_latched", fault_latched, 1);
    check("fault_en_low", machine_en, 0);
    fault_clear = 1; step(); fault_clear = 0;
    check("clear_while_fault", fault_latched, 1);
    fault = 0; step();
    check("fault_gone_still_latched", fault_latched, 1);
    fault_clear = 1; step(); fault_clear = 0;
    check("fault_cleared", fault_latched, 0);
    check("cleared_en_low", machine_en, 0);
    step();
    check("no_implied_start", machine_en, 0);

    // 6. commit timeout while RUNNING with pulse_idle low
    pulse_start_key();
    check("restart_run", machine_en, 1);
    pulse_idle = 0;
    strobe(4'b0010, 64'd2000 << 16);
    check("toff_pending", pending, 4'b0010);
    tmo_pulses = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (commit_timeout === 1'b1) tmo_pulses++;
      check($sformatf("tmo_cycle%0d", k), commit_timeout, (k == 50) ? 1 : 0);
    end
    check("tmo_pulse_count", tmo_pulses, 1);
    check("tmo_pending_kept", pending, 4'b0010);
    check("tmo_Toff_held", Toff_q, 1000);
    stop_req_key = 1; step(); stop_req_key = 0;
    check("tmo_drain_en", machine_en, 0);
    check("tmo_drain_Toff", Toff_q, 1000);
    step();
    check("drain_commit_Toff", Toff_q, 2000);
    check("drain_commit_pending", pending, 0);
    step();
    check("drain_commit_pulse", param_commit, 1);
    pulse_idle = 1;
    step();

    // reset mid-operation drops pending updates
    pulse_start_key();
    pulse_idle = 0;
    strobe(4'b0001, 64'd250);
    check("pre_reset_pending", pending, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pending", pending, 0);
    check("midrst_Ton_q", Ton_q, 100);
    check("midrst_Toff_q", Toff_q, 1000);
    check("midrst_en", machine_en, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
